hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have a parameter LOAD_LAT, default 1, range 1..7, giving the load-use stall length in cycles.
REQ-002 The block SHALL have a parameter CNT_W, default 16, giving the width of the statistics counters.
REQ-003 clk  in  1  the single clock; every register updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 iIdRs, iIdRt  in  5 each  source register fields of the instruction in ID.
REQ-006 iIdUsesRt  in  1  the ID instruction reads rt.
REQ-007 iExMemRead, iExRt  in  1, 5  the ID_EX register's MemRead output and its rt field (bits 20:16).
REQ-008 iBranchTaken  in  1  branch resolved taken in the MEM stage.
REQ-009 iMemBusy  in  1  data memory is not ready this cycle.
REQ-010 oPCWrite, oIFIDWrite, oIDEXWrite, oEXMEMWrite  out  1 each  register write enables.
REQ-011 oIFIDFlush, oIDEXBubble, oEXMEMFlush  out  1 each  clear the contents or control bits of each register on its next write.
REQ-012 oState  out  2  current FSM state.
REQ-013 oStallCount, oFlushCount  out  CNT_W each  statistics counters.

Function
REQ-014 The FSM SHALL have three states, encoded RUN=0, LOAD_STALL=1, MEM_WAIT=2.
REQ-015 A load-use hazard SHALL be defined as iExMemRead=1, iExRt!=0, and either iExRt==iIdRs or (iIdUsesRt=1 and iExRt==iIdRt).
REQ-016 Outputs SHALL be combinational from the current state and inputs (Mealy), using the priority rst > iMemBusy > iBranchTaken > stall condition.
REQ-017 Default outputs SHALL be: all write enables 1; all flush and bubble signals 0.
REQ-018 While iMemBusy=1, in any state, all four write enables SHALL be 0 and flush/bubble SHALL be 0.
REQ-019 On iMemBusy=1 the next state SHALL be MEM_WAIT, and the block SHALL save the state it came from (RUN or LOAD_STALL) plus the remaining-cycle counter.
REQ-020 In MEM_WAIT with iMemBusy=0, the block SHALL evaluate outputs and next state exactly as the saved state would.
REQ-021 The remaining-cycle counter SHALL be frozen during MEM_WAIT.
REQ-022 With iBranchTaken=1 and iMemBusy=0, the block SHALL assert oIFIDFlush, oIDEXBubble and oEXMEMFlush with all write enables 1.
REQ-023 A taken branch SHALL send the next state to RUN, aborting any load stall in progress and clearing the remaining-cycle counter.
REQ-024 A load-use hazard in RUN SHALL produce oPCWrite=0, oIFIDWrite=0 and oIDEXBubble=1 that cycle.
REQ-025 After a load-use hazard in RUN, the next state SHALL be RUN if LOAD_LAT=1; otherwise LOAD_STALL with remaining = LOAD_LAT-1.
REQ-026 In LOAD_STALL, the block SHALL drive the same stall outputs and decrement remaining; when remaining=1 the next state SHALL be RUN.
REQ-027 Total stall length SHALL be exactly LOAD_LAT cycles.
REQ-028 A hazard still present when LOAD_STALL returns to RUN SHALL be re-evaluated normally in RUN.
REQ-029 oStallCount SHALL increment once per cycle in which oIDEXBubble=1 because of a load stall.
REQ-030 oFlushCount SHALL increment once per taken-branch flush cycle.
REQ-031 Both counters SHALL saturate at all-ones and SHALL NOT increment during iMemBusy cycles.
REQ-032 iExRt=0 SHALL never cause a stall, even when iIdRs=0.

Reset
REQ-033 While rst=1: state=RUN, remaining=0, saved state=RUN, both counters 0.
REQ-034 While rst=1, outputs SHALL be forced to the defaults of REQ-017 regardless of other inputs.
REQ-035 Reset asserted mid-stall or mid-MEM_WAIT SHALL take effect at the next edge; the first cycle after rst deasserts SHALL be RUN with no residual stall.

Verification
REQ-036 LOAD_LAT=1; iExMemRead=1, iExRt=5, iIdRs=5 for one cycle -> exactly 1 cycle of oPCWrite=0/oIDEXBubble=1, then RUN with defaults; oStallCount=1.
REQ-037 LOAD_LAT=3; same hazard for one cycle -> stall outputs for 3 consecutive cycles, oState sequence 0,1,1,0; oStallCount=3.
REQ-038 LOAD_LAT=3; hazard, then iMemBusy=1 for 2 cycles during LOAD_STALL -> all enables 0 with oState=2 for 2 cycles, then the remaining stall cycles complete; total bubbles=3.
REQ-039 iBranchTaken=1 together with the load-use condition -> flush outputs, no stall, oFlushCount=1, next oState=0.
REQ-040 iBranchTaken=1 and iMemBusy=1 together -> freeze only; when busy drops with branch still 1 -> one flush cycle.
REQ-041 iExRt=0 with iIdRs=0 and iExMemRead=1 -> no stall; rst during LOAD_STALL -> next cycle oState=0 and both counters 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and data-memory
// wait freezes, with saturating stall/flush statistics counters.
module hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       iIdRs,
  input  logic [4:0]       iIdRt,
  input  logic             iIdUsesRt,
  input  logic             iExMemRead,
  input  logic [4:0]       iExRt,
  input  logic             iBranchTaken,
  input  logic             iMemBusy,
  output logic             oPCWrite,
  output logic             oIFIDWrite,
  output logic             oIDEXWrite,
  output logic             oEXMEMWrite,
  output logic             oIFIDFlush,
  output logic             oIDEXBubble,
  output logic             oEXMEMFlush,
  output logic [1:0]       oState,
  output logic [CNT_W-1:0] oStallCount,
  output logic [CNT_W-1:0] oFlushCount
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  state_t     state;
  state_t     savedState;
  state_t     evalState;
  logic [2:0] remaining;
  logic       loadUse;
  logic       busyNow;
  logic       flushNow;
  logic       stallNow;

  // MEM_WAIT behaves exactly like the state it interrupted once memory is ready.
  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    loadUse   = iExMemRead && (iExRt != 5'd0) &&
                ((iExRt == iIdRs) || (iIdUsesRt && (iExRt == iIdRt)));
    evalState = (state == MEM_WAIT) ? savedState : state;
    busyNow   = !rst && iMemBusy;
    flushNow  = !rst && !iMemBusy && iBranchTaken;
    stallNow  = !rst && !iMemBusy && !iBranchTaken &&
                ((evalState == LOAD_STALL) || ((evalState == RUN) && loadUse));

    oPCWrite    = !(busyNow || stallNow);
    oIFIDWrite  = !(busyNow || stallNow);
    oIDEXWrite  = !busyNow;
    oEXMEMWrite = !busyNow;
    oIFIDFlush  = flushNow;
    oIDEXBubble = flushNow || stallNow;
    oEXMEMFlush = flushNow;
    oState      = state;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      savedState  <= RUN;
      remaining   <= 3'd0;
      oStallCount <= '0;
      oFlushCount <= '0;
    end else begin
      if (iMemBusy) begin
        if (state != MEM_WAIT) savedState <= state;
        state <= MEM_WAIT;
      end else if (iBranchTaken) begin
        state      <= RUN;
        savedState <= RUN;
        remaining  <= 3'd0;
      end else if (evalState == LOAD_STALL) begin
        if (remaining <= 3'd1) begin
          state     <= RUN;
          remaining <= 3'd0;
        end else begin
          state     <= LOAD_STALL;
          remaining <= remaining - 3'd1;
        end
      end else if (loadUse) begin
        state     <= (LOAD_LAT == 1) ? RUN : LOAD_STALL;
        remaining <= LAT_M1;
      end else begin
        state <= RUN;
      end

      // Counters saturate and never move during memory-wait cycles.
      if (stallNow && (oStallCount != '1)) oStallCount <= oStallCount + CNT_W'(1);
      if (flushNow && (oFlushCount != '1)) oFlushCount <= oFlushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_LAT=1 and 3) share stimulus and are
// compared each cycle against a stall-cycles-remaining reference model.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       rd;
    logic [4:0] exRt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic       br;
    logic       busy;
  } stim_t;

  logic clk = 1'b0;
  logic rst, iIdUsesRt, iExMemRead, iBranchTaken, iMemBusy;
  logic [4:0] iIdRs, iIdRt, iExRt;

  wire [6:0] ctlA, ctlB;
  wire [1:0] stA, stB;
  wire [3:0] stallA, flushA;
  wire [4:0] stallB, flushB;

  logic [6:0]  actCtl[2];
  logic [1:0]  actSt[2];
  logic [15:0] actStall[2];
  logic [15:0] actFlush[2];

  logic [6:0] expCtl[2];
  logic [1:0] expSt[2];
  int expStall[2], expFlush[2];

  int pend[2]   = '{0, 0};
  int mStall[2] = '{0, 0};
  int mFlush[2] = '{0, 0};
  bit waitF = 1'b0;
  int lat[2]  = '{1, 3};
  int cmax[2] = '{15, 31};
  stim_t curS;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(1), .CNT_W(4)) dutA (
    .clk(clk), .rst(rst), .iIdRs(iIdRs), .iIdRt(iIdRt), .iIdUsesRt(iIdUsesRt),
    .iExMemRead(iExMemRead), .iExRt(iExRt), .iBranchTaken(iBranchTaken), .iMemBusy(iMemBusy),
    .oPCWrite(ctlA[6]), .oIFIDWrite(ctlA[5]), .oIDEXWrite(ctlA[4]), .oEXMEMWrite(ctlA[3]),
    .oIFIDFlush(ctlA[2]), .oIDEXBubble(ctlA[1]), .oEXMEMFlush(ctlA[0]),
    .oState(stA), .oStallCount(stallA), .oFlushCount(flushA)
  );

  hazard_ctrl #(.LOAD_LAT(3), .CNT_W(5)) dutB (
    .clk(clk), .rst(rst), .iIdRs(iIdRs), .iIdRt(iIdRt), .iIdUsesRt(iIdUsesRt),
    .iExMemRead(iExMemRead), .iExRt(iExRt), .iBranchTaken(iBranchTaken), .iMemBusy(iMemBusy),
    .oPCWrite(ctlB[6]), .oIFIDWrite(ctlB[5]), .oIDEXWrite(ctlB[4]), .oEXMEMWrite(ctlB[3]),
    .oIFIDFlush(ctlB[2]), .oIDEXBubble(ctlB[1]), .oEXMEMFlush(ctlB[0]),
    .oState(stB), .oStallCount(stallB), .oFlushCount(flushB)
  );

  always_comb begin
    actCtl[0] = ctlA;  actSt[0] = stA;  actStall[0] = 16'(stallA);  actFlush[0] = 16'(flushA);
    actCtl[1] = ctlB;  actSt[1] = stB;  actStall[1] = 16'(stallB);  actFlush[1] = 16'(flushB);
  end

  function automatic stim_t mk(input logic r, input logic rd, input int exRt, input int rs,
                               input int rt, input logic uses, input logic br, input logic busy);
    stim_t s;
    s.rst = r; s.rd = rd; s.exRt = 5'(exRt); s.rs = 5'(rs); s.rt = 5'(rt);
    s.uses = uses; s.br = br; s.busy = busy;
    return s;
  endfunction

  function automatic bit isHazard(input stim_t s);
    return s.rd && (s.exRt != 0) && ((s.exRt == s.rs) || (s.uses && (s.exRt == s.rt)));
  endfunction

  // Drive one cycle of inputs and derive the expected outputs from the model.
  task automatic apply(input stim_t s);
    curS = s;
    rst = s.rst; iExMemRead = s.rd; iExRt = s.exRt; iIdRs = s.rs; iIdRt = s.rt;
    iIdUsesRt = s.uses; iBranchTaken = s.br; iMemBusy = s.busy;
    #1;
    for (int d = 0; d < 2; d++) begin
      expSt[d]    = waitF ? 2'd2 : ((pend[d] > 0) ? 2'd1 : 2'd0);
      expStall[d] = mStall[d];
      expFlush[d] = mFlush[d];
      if (s.rst)                          expCtl[d] = 7'b1111000;
      else if (s.busy)                    expCtl[d] = 7'b0000000;
      else if (s.br)                      expCtl[d] = 7'b1111111;
      else if (pend[d] > 0 || isHazard(s)) expCtl[d] = 7'b0011010;
      else                                expCtl[d] = 7'b1111000;
    end
  endtask

  // Advance the model across the clock edge and wait for the next sampling point.
  task automatic tick();
    if (curS.rst) begin
      waitF = 1'b0;
      for (int d = 0; d < 2; d++) begin pend[d] = 0; mStall[d] = 0; mFlush[d] = 0; end
    end else if (curS.busy) begin
      waitF = 1'b1;
    end else begin
      waitF = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (curS.br) begin
          pend[d] = 0;
          if (mFlush[d] < cmax[d]) mFlush[d]++;
        end else if (pend[d] > 0) begin
          pend[d]--;
          if (mStall[d] < cmax[d]) mStall[d]++;
        end else if (isHazard(curS)) begin
          pend[d] = lat[d] - 1;
          if (mStall[d] < cmax[d]) mStall[d]++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t seq[$];
    seq.push_back(mk(1, 1, 5, 5, 5, 1, 1, 1));
    seq.push_back(mk(1, 1, 7, 7, 0, 0, 0, 0));
    seq.push_back(mk(0, 1, 5, 5, 0, 0, 0, 0));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    seq.push_back(mk(1, 1, 5, 5, 0, 0, 0, 0));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    seq.push_back(mk(0, 1, 5, 5, 0, 0, 0, 0));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
    foreach (seq[i]) begin
      apply(seq[i]);
      for (int d = 0; d < 2; d++) begin
        nChecks += 4;
        if (actCtl[d] !== expCtl[d]) begin nFails++; $display("FAIL reset dut%0d cyc%0d ctl: got %b want %b", d, i, actCtl[d], expCtl[d]); end
        if (actSt[d] !== expSt[d]) begin nFails++; $display("FAIL reset dut%0d cyc%0d state: got %0d want %0d", d, i, actSt[d], expSt[d]); end
        if (actStall[d] !== 16'(expStall[d])) begin nFails++; $display("FAIL reset dut%0d cyc%0d stallCount: got %0d want %0d", d, i, actStall[d], expStall[d]); end
        if (actFlush[d] !== 16'(expFlush[d])) begin nFails++; $display("FAIL reset dut%0d cyc%0d flushCount: got %0d want %0d", d, i, actFlush[d], expFlush[d]); end
      end
      tick();
    end
    nChecks += 2;
    if (stB !== 2'd0) begin nFails++; $display("FAIL reset_exit state: got %0d want 0", stB); end
    if (stallB !== 5'd0) begin nFails++; $display("FAIL reset_exit stallCount: got %0d want 0", stallB); end
  endtask

  task automatic test_load_use();
    stim_t seq[$];
    int bubbles[2] = '{0, 0};
    logic [1:0] stSeqB[$];
    seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    seq.push_back(mk(0, 1, 5, 5, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    seq.push_back(mk(0, 1, 9, 3, 9, 0, 0, 0));
    seq.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0));
    foreach (seq[i]) begin
      apply(seq[i]);
      for (int d = 0; d < 2; d++) begin
        nChecks += 4;
        if (actCtl[d] !== expCtl[d]) begin nFails++; $display("FAIL load_use dut%0d cyc%0d ctl: got %b want %b", d, i, actCtl[d], expCtl[d]); end
        if (actSt[d] !== expSt[d]) begin nFails++; $display("FAIL load_use dut%0d cyc%0d state: got %0d want %0d", d, i, actSt[d], expSt[d]); end
        if (actStall[d] !== 16'(expStall[d])) begin nFails++; $display("FAIL load_use dut%0d cyc%0d stallCount: got %0d want %0d", d, i, actStall[d], expStall[d]); end
        if (actFlush[d] !== 16'(expFlush[d])) begin nFails++; $display("FAIL load_use dut%0d cyc%0d flushCount: got %0d want %0d", d, i, actFlush[d], expFlush[d]); end
        if (i >= 1 && i <= 5 && actCtl[d][1] === 1'b1) bubbles[d]++;
      end
      if (i >= 1 && i <= 4) stSeqB.push_back(stB);
      tick();
    end
    nChecks += 7;
    if (bubbles[0] != 1) begin nFails++; $display("FAIL lat1_bubbles: got %0d want 1", bubbles[0]); end
    if (bubbles[1] != 3) begin nFails++; $display("FAIL lat3_bubbles: got %0d want 3", bubbles[1]); end
    if (stSeqB[0] !== 2'd0) begin nFails++; $display("FAIL lat3_state0: got %0d want 0", stSeqB[0]); end
    if (stSeqB[1] !== 2'd1) begin nFails++; $display("FAIL lat3_state1: got %0d want 1", stSeqB[1]); end
    if (stSeqB[2] !== 2'd1) begin nFails++; $display("FAIL lat3_state2: got %0d want 1", stSeqB[2]); end
    if (stSeqB[3] !== 2'd0) begin nFails++; $display("FAIL lat3_state3: got %0d want 0", stSeqB[3]); end
    if (stallA !== 4'd1) begin nFails++; $display("FAIL lat1_stallCount: got %0d want 1", stallA); end
  endtask

  task automatic test_mem_wait();
    stim_t seq[$];
    int bubblesB = 0;
    int waitCyc = 0;
    seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    seq.push_back(mk(0, 1, 5, 5, 0, 0, 0, 0));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    seq.push_back(mk(0, 1, 5, 5, 0, 0, 0, 1));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++) seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (seq[i]) begin
      apply(seq[i]);
      for (int d = 0; d < 2; d++) begin
        nChecks += 4;
        if (actCtl[d] !== expCtl[d]) begin nFails++; $display("FAIL mem_wait dut%0d cyc%0d ctl: got %b want %b", d, i, actCtl[d], expCtl[d]); end
        if (actSt[d] !== expSt[d]) begin nFails++; $display("FAIL mem_wait dut%0d cyc%0d state: got %0d want %0d", d, i, actSt[d], expSt[d]); end
        if (actStall[d] !== 16'(expStall[d])) begin nFails++; $display("FAIL mem_wait dut%0d cyc%0d stallCount: got %0d want %0d", d, i, actStall[d], expStall[d]); end
        if (actFlush[d] !== 16'(expFlush[d])) begin nFails++; $display("FAIL mem_wait dut%0d cyc%0d flushCount: got %0d want %0d", d, i, actFlush[d], expFlush[d]); end
      end
      if (i >= 1 && ctlB[1] === 1'b1) bubblesB++;
      if (stB === 2'd2) waitCyc++;
      tick();
    end
    nChecks += 3;
    if (bubblesB != 3) begin nFails++; $display("FAIL mem_wait_bubbles: got %0d want 3", bubblesB); end
    if (waitCyc != 2) begin nFails++; $display("FAIL mem_wait_cycles: got %0d want 2", waitCyc); end
    if (stallB !== 5'd3) begin nFails++; $display("FAIL mem_wait_stallCount: got %0d want 3", stallB); end
  endtask

  task automatic test_branch();
    stim_t seq[$];
    seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    seq.push_back(mk(0, 1, 5, 5, 0, 0, 1, 0));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    seq.push_back(mk(0, 1, 6, 2, 6, 1, 0, 0));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    seq.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (seq[i]) begin
      apply(seq[i]);
      for (int d = 0; d < 2; d++) begin
        nChecks += 4;
        if (actCtl[d] !== expCtl[d]) begin nFails++; $display("FAIL branch dut%0d cyc%0d ctl: got %b want %b", d, i, actCtl[d], expCtl[d]); end
        if (actSt[d] !== expSt[d]) begin nFails++; $display("FAIL branch dut%0d cyc%0d state: got %0d want %0d", d, i, actSt[d], expSt[d]); end
        if (actStall[d] !== 16'(expStall[d])) begin nFails++; $display("FAIL branch dut%0d cyc%0d stallCount: got %0d want %0d", d, i, actStall[d], expStall[d]); end
        if (actFlush[d] !== 16'(expFlush[d])) begin nFails++; $display("FAIL branch dut%0d cyc%0d flushCount: got %0d want %0d", d, i, actFlush[d], expFlush[d]); end
      end
      if (i == 2) begin
        nChecks += 3;
        if (flushA !== 4'd1) begin nFails++; $display("FAIL branch_flushCount: got %0d want 1", flushA); end
        if (stB !== 2'd0) begin nFails++; $display("FAIL branch_next_state: got %0d want 0", stB); end
        if (stallB !== 5'd0) begin nFails++; $display("FAIL branch_no_stall: got %0d want 0", stallB); end
      end
      tick();
    end
    nChecks += 1;
    if (flushB !== 5'd3) begin nFails++; $display("FAIL branch_total_flushes: got %0d want 3", flushB); end
  endtask

  task automatic test_saturation();
    stim_t seq[$];
    seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 20; k++) seq.push_back(mk(0, 1, 4, 4, 0, 0, 0, 0));
    for (int k = 0; k < 20; k++) seq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    seq.push_back(mk(0, 1, 4, 4, 0, 0, 0, 1));
    foreach (seq[i]) begin
      apply(seq[i]);
      for (int d = 0; d < 2; d++) begin
        nChecks += 4;
        if (actCtl[d] !== expCtl[d]) begin nFails++; $display("FAIL saturation dut%0d cyc%0d ctl: got %b want %b", d, i, actCtl[d], expCtl[d]); end
        if (actSt[d] !== expSt[d]) begin nFails++; $display("FAIL saturation dut%0d cyc%0d state: got %0d want %0d", d, i, actSt[d], expSt[d]); end
        if (actStall[d] !== 16'(expStall[d])) begin nFails++; $display("FAIL saturation dut%0d cyc%0d stallCount: got %0d want %0d", d, i, actStall[d], expStall[d]); end
        if (actFlush[d] !== 16'(expFlush[d])) begin nFails++; $display("FAIL saturation dut%0d cyc%0d flushCount: got %0d want %0d", d, i, actFlush[d], expFlush[d]); end
      end
      tick();
    end
    nChecks += 3;
    if (stallA !== 4'hF) begin nFails++; $display("FAIL sat_stallCount: got %0d want 15", stallA); end
    if (flushA !== 4'hF) begin nFails++; $display("FAIL sat_flushCount: got %0d want 15", flushA); end
    if (stallB !== 5'd20) begin nFails++; $display("FAIL lat3_continuous_stalls: got %0d want 20", stallB); end
  endtask

  task automatic test_random();
    stim_t s;
    for (int i = 0; i < 800; i++) begin
      s = mk($urandom_range(0, 79) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
      apply(s);
      for (int d = 0; d < 2; d++) begin
        nChecks += 4;
        if (actCtl[d] !== expCtl[d]) begin nFails++; $display("FAIL random dut%0d cyc%0d ctl: got %b want %b", d, i, actCtl[d], expCtl[d]); end
        if (actSt[d] !== expSt[d]) begin nFails++; $display("FAIL random dut%0d cyc%0d state: got %0d want %0d", d, i, actSt[d], expSt[d]); end
        if (actStall[d] !== 16'(expStall[d])) begin nFails++; $display("FAIL random dut%0d cyc%0d stallCount: got %0d want %0d", d, i, actStall[d], expStall[d]); end
        if (actFlush[d] !== 16'(expFlush[d])) begin nFails++; $display("FAIL random dut%0d cyc%0d flushCount: got %0d want %0d", d, i, actFlush[d], expFlush[d]); end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; iExMemRead = 1'b0; iExRt = '0; iIdRs = '0; iIdRt = '0;
    iIdUsesRt = 1'b0; iBranchTaken = 1'b0; iMemBusy = 1'b0;
    curS = mk(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
